mem_responder: RTL and testbench

//  Responder end of the core's memory request/response interface: the block that answers the

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response channel between a memory initiator (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int Width = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [Width-1:0]   req_addr;
  logic               req_we;
  logic [Width-1:0]   req_wdata;
  logic [Width/8-1:0] req_wstrb;
  logic               resp_valid;
  logic               resp_ready;
  logic [Width-1:0]   resp_data;
  logic               resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM answering in-order requests after a fixed latency; a credit counter
// bounds requests in flight so the response FIFO can never overflow.
module mem_responder #(
  parameter int Width       = 32,
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int Lanes = Width / 8;
  localparam int OffW  = $clog2(Lanes);
  localparam int IdxW  = $clog2(DEPTH);
  localparam int CntW  = $clog2(OUTSTANDING + 1);
  localparam int PtrW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [Width-1:0] AddrMask = Width'(DEPTH - 1) << OffW;

  typedef struct packed {
    logic [Width-1:0] data;
    logic             err;
  } resp_t;

  logic            w_accept;
  logic            w_consume;
  logic            w_err;
  logic [IdxW-1:0] w_idx;
  resp_t           w_resp_new;
  logic            w_push;
  resp_t           w_push_data;

  logic [CntW-1:0]  r_credits;
  logic [CntW-1:0]  r_count;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [Width-1:0] r_mem  [DEPTH];
  resp_t            r_fifo [OUTSTANDING];

  assign bus.req_ready = (r_credits < CntW'(OUTSTANDING));
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_consume     = bus.resp_valid && bus.resp_ready;
  assign w_idx         = bus.req_addr[OffW +: IdxW];
  assign w_err         = |(bus.req_addr & ~AddrMask);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    w_resp_new     = '0;
    w_resp_new.err = w_err;
    if (!w_err && !bus.req_we) w_resp_new.data = r_mem[w_idx];
  end

  // NOTE: the RAM and FIFO storage have no reset; only their control state is cleared by rst.
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_we && !w_err) begin
      for (int b = 0; b < Lanes; b++) begin
        if (bus.req_wstrb[b]) r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (rst) begin
      r_credits <= '0;
    end else if (w_accept && !w_consume) begin
      r_credits <= r_credits + CntW'(1);
    end else if (!w_accept && w_consume) begin
      r_credits <= r_credits - CntW'(1);
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign w_push      = w_accept;
      assign w_push_data = w_resp_new;
    end else begin : g_delay
      logic [LATENCY-2:0] r_vld;
      resp_t              r_stage [LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          for (int s = 0; s < LATENCY - 1; s++) r_stage[s] <= '0;
        end else begin
          r_vld[0]   <= w_accept;
          r_stage[0] <= w_resp_new;
          for (int s = 1; s < LATENCY - 1; s++) begin
            r_vld[s]   <= r_vld[s-1];
            r_stage[s] <= r_stage[s-1];
          end
        end
      end

      assign w_push      = r_vld[LATENCY-2];
      assign w_push_data = r_stage[LATENCY-2];
    end
  endgenerate

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_consume) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_consume)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_consume) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  // Head fields are forced to zero when empty so stale entries never reach the outputs.
  assign bus.resp_valid = (r_count != '0);
  assign bus.resp_data  = bus.resp_valid ? r_fifo[r_rd_ptr].data : '0;
  assign bus.resp_err   = bus.resp_valid && r_fifo[r_rd_ptr].err;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a word-array model predicts data, error and the
// cycle each response must appear; a monitor compares whatever the DUT presents.
module tb_mem_responder;
  localparam int Width = 32;
  localparam int Depth = 1024;
  localparam int Lat   = 2;
  localparam int Outs  = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  mem_responder_if #(.Width(Width)) bus_if ();

  mem_responder #(
    .Width(Width), .DEPTH(Depth), .LATENCY(Lat), .OUTSTANDING(Outs)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          credits = 0;
  int          drv_acc_cyc = -1;
  int          mon_pop_cyc = -1;
  int          last_pop = -100;
  bit          running = 1'b0;
  exp_t        sb[$];
  logic [31:0] mdl [Depth];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One request cycle; accepted iff the model holds fewer than Outs credits.
  task automatic drive(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                       input logic [3:0] strb, output bit acc);
    exp_t e;
    int   idx;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = addr;
    bus_if.req_we    = we;
    bus_if.req_wdata = wdata;
    bus_if.req_wstrb = strb;
    acc = (credits < Outs);
    if (acc) begin
      e.err  = (addr[1:0] != 2'b00) || (addr >= 32'(Depth * 4));
      e.data = '0;
      idx    = int'(addr[11:2]);
      if (!e.err) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          e.data = mdl[idx];
        end
      end
      e.rdy = cyc + Lat;
      sb.push_back(e);
      drv_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                      input logic [3:0] strb);
    bit acc;
    int tries = 0;
    do begin
      drive(addr, we, wdata, strb, acc);
      tries++;
    end while (!acc && tries < 100);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: request %h never accepted", addr);
    end
  endtask

  task automatic idle(input int n);
    bus_if.req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int waited = 0;
    bus_if.resp_ready = 1'b1;
    while (sb.size() != 0 && waited < 200) begin idle(1); waited++; end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    sb.delete();
    drv_acc_cyc = -1;
    credits = 0;
    #1;
    check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("rst_resp_data", bus_if.resp_data, 32'd0);
    check("rst_resp_err", 32'(bus_if.resp_err), 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic credit_loop();
    forever begin
      @(posedge clk);
      if (rst) credits = 0;
      else begin
        if (drv_acc_cyc == cyc) credits++;
        if (mon_pop_cyc == cyc) credits--;
      end
      cyc++;
    end
  endtask

  task automatic monitor_loop();
    int vis;
    forever begin
      @(negedge clk);
      if (!rst && running) begin
        check("req_ready", 32'(bus_if.req_ready), 32'(credits < Outs));
        if (sb.size() == 0) begin
          check("idle_valid", 32'(bus_if.resp_valid), 32'd0);
        end else begin
          vis = (sb[0].rdy > last_pop + 1) ? sb[0].rdy : last_pop + 1;
          if (cyc < vis) begin
            check("early_valid", 32'(bus_if.resp_valid), 32'd0);
          end else begin
            check("resp_valid", 32'(bus_if.resp_valid), 32'd1);
            if (bus_if.resp_valid) begin
              check("resp_data", bus_if.resp_data, sb[0].data);
              check("resp_err", 32'(bus_if.resp_err), 32'(sb[0].err));
              if (bus_if.resp_ready) begin
                void'(sb.pop_front());
                last_pop = cyc;
                mon_pop_cyc = cyc;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic run_tests();
    bit          acc;
    logic [31:0] a;
    bus_if.req_valid  = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_we     = 1'b0;
    bus_if.req_wdata  = '0;
    bus_if.req_wstrb  = '0;
    bus_if.resp_ready = 1'b0;
    #1;
    do_reset(3);
    running = 1'b1;
    bus_if.resp_ready = 1'b1;

    for (int w = 0; w < 32; w++) send(32'(w * 4), 1'b1, $urandom, 4'hF);
    drain();

    // Full write then read-back of the same word.
    send(32'h100, 1'b1, 32'hDEADBEEF, 4'hF);
    send(32'h100, 1'b0, 32'h0, 4'h0);
    drain();

    // Byte-lane merge.
    send(32'h104, 1'b1, 32'h11223344, 4'hF);
    send(32'h104, 1'b1, 32'hAABBCCDD, 4'b0011);
    send(32'h104, 1'b0, 32'h0, 4'h0);
    drain();

    // Misaligned and out-of-range accesses must not touch the RAM.
    send(32'h102, 1'b0, 32'h0, 4'h0);
    send(32'h102, 1'b1, 32'h55555555, 4'hF);
    send(32'h4000_0000, 1'b0, 32'h0, 4'h0);
    send(32'h4000_0100, 1'b1, 32'h66666666, 4'hF);
    send(32'h100, 1'b0, 32'h0, 4'h0);
    drain();

    // Backpressure: only Outs requests fit while responses are held.
    bus_if.resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(32'(i * 4), 1'b0, 32'h0, 4'h0, acc);
    idle(3);
    drain();

    // Back-to-back streaming.
    for (int i = 0; i < 4; i++) send(32'(i * 4), 1'b0, 32'h0, 4'h0);
    drain();

    // Reset with three requests in flight; the write among them persists.
    bus_if.resp_ready = 1'b0;
    send(32'h0, 1'b0, 32'h0, 4'h0);
    send(32'h108, 1'b1, 32'hCAFEF00D, 4'hF);
    send(32'h4, 1'b0, 32'h0, 4'h0);
    #2;
    do_reset(2);
    bus_if.resp_ready = 1'b1;
    idle(8);
    send(32'h108, 1'b0, 32'h0, 4'h0);
    send(32'h100, 1'b0, 32'h0, 4'h0);
    send(32'h104, 1'b0, 32'h0, 4'h0);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus_if.resp_ready = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(9))
          0:       a = 32'($urandom_range(31) * 4) | 32'($urandom_range(3, 1));
          1:       a = 32'h1000 | 32'($urandom_range(255) * 4);
          default: a = 32'($urandom_range(31) * 4);
        endcase
        drive(a, 1'($urandom), $urandom, 4'($urandom), acc);
      end
    end
    drain();
  endtask

  initial begin
    fork
      run_tests();
      credit_loop();
      monitor_loop();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
